// File: rtl/cpu_defs.sv
// Shared definitions for the instruction sequencer: state and class
// encodings, opcode/funct constants, and the pc_src/reg_wsel codes.
package cpu_defs;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5
  } state_t;

  // CLS_ALU is the all-zero value so a reset class register reads as ALU.
  typedef enum logic [3:0] {
    CLS_ALU  = 4'd0,
    CLS_J    = 4'd1,
    CLS_JAL  = 4'd2,
    CLS_JR   = 4'd3,
    CLS_JALR = 4'd4,
    CLS_BEQ  = 4'd5,
    CLS_BNE  = 4'd6,
    CLS_LW   = 4'd7,
    CLS_SW   = 4'd8
  } class_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_SRA  = 6'h03;
  localparam logic [5:0] FUNCT_JR   = 6'h08;
  localparam logic [5:0] FUNCT_JALR = 6'h09;
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_XOR  = 6'h26;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;

  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_REG    = 2'b11;

  localparam logic [1:0] WSEL_ALU  = 2'b00;
  localparam logic [1:0] WSEL_MEM  = 2'b01;
  localparam logic [1:0] WSEL_LINK = 2'b10;

endpackage

// File: rtl/instr_classifier.sv
// Combinational instruction classifier: maps op/funct to a class and a
// legality flag. Illegal encodings report CLS_ALU with legal=0.
module instr_classifier
  import cpu_defs::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output class_t     cls,
  output logic       legal
);

  // Decode opcode, and funct for R-type, into an instruction class.
  always_comb begin
    cls   = CLS_ALU;
    legal = 1'b1;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FUNCT_JR:   cls = CLS_JR;
          FUNCT_JALR: cls = CLS_JALR;
          FUNCT_SLL, FUNCT_SRL, FUNCT_SRA,
          FUNCT_ADD, FUNCT_ADDU, FUNCT_SUB, FUNCT_SUBU,
          FUNCT_AND, FUNCT_OR, FUNCT_XOR, FUNCT_NOR,
          FUNCT_SLT:  cls = CLS_ALU;
          default:    legal = 1'b0;
        endcase
      end
      OP_J:    cls = CLS_J;
      OP_JAL:  cls = CLS_JAL;
      OP_BEQ:  cls = CLS_BEQ;
      OP_BNE:  cls = CLS_BNE;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI: cls = CLS_ALU;
      OP_LW:   cls = CLS_LW;
      OP_SW:   cls = CLS_SW;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: fetch/decode/exec/mem/writeback
// control with a bounded memory wait and a bus-error abort path.
// Memory handshake: mem_req is held high in FETCH/MEM until a cycle in
// which mem_ready is high; that cycle completes the access. If
// MEM_TIMEOUT request cycles pass without mem_ready, the access is
// abandoned with a one-cycle bus_err and the instruction is refetched.
module cpu_sequencer
  import cpu_defs::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       ir_wren,
  output logic       pc_wren,
  output logic [1:0] pc_src,
  output logic       mem_req,
  output logic       mem_wren,
  output logic       mem_addr_sel,
  output logic       reg_file_wren,
  output logic [1:0] reg_wsel,
  output logic       retired,
  output logic       illegal,
  output logic       bus_err,
  output logic [2:0] state
);

  // Value of the wait counter during the last allowed request cycle.
  localparam logic [3:0] WAIT_LAST = 4'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  class_t     cls_q, dec_cls;
  logic       dec_legal;
  logic [3:0] wait_q;

  instr_classifier u_classifier (
    .op    (op),
    .funct (funct),
    .cls   (dec_cls),
    .legal (dec_legal)
  );

  assign state = state_q;

  // State, latched class and memory wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cls_q   <= CLS_ALU;
      wait_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE) cls_q <= dec_cls;
      if ((state_d != state_q) || bus_err) wait_q <= 4'd0;
      else if (mem_req && !mem_ready)      wait_q <= wait_q + 4'd1;
    end
  end

  // Next-state and output decode; mem_ready beats a coincident timeout.
  always_comb begin
    state_d       = state_q;
    ir_wren       = 1'b0;
    pc_wren       = 1'b0;
    pc_src        = PC_SRC_SEQ;
    mem_req       = 1'b0;
    mem_wren      = 1'b0;
    mem_addr_sel  = 1'b0;
    reg_file_wren = 1'b0;
    reg_wsel      = WSEL_ALU;
    retired       = 1'b0;
    illegal       = 1'b0;
    bus_err       = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_wren = 1'b1;
          pc_wren = 1'b1;
          state_d = ST_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          bus_err = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        state_d = ST_FETCH;
        if (!dec_legal) begin
          illegal = 1'b1;
        end else begin
          case (dec_cls)
            CLS_J, CLS_JAL: begin
              pc_wren = 1'b1;
              pc_src  = PC_SRC_JUMP;
              retired = 1'b1;
              if (dec_cls == CLS_JAL) begin
                reg_file_wren = 1'b1;
                reg_wsel      = WSEL_LINK;
              end
            end
            CLS_JR, CLS_JALR: begin
              pc_wren = 1'b1;
              pc_src  = PC_SRC_REG;
              retired = 1'b1;
              if (dec_cls == CLS_JALR) begin
                reg_file_wren = 1'b1;
                reg_wsel      = WSEL_LINK;
              end
            end
            default: state_d = ST_EXEC;
          endcase
        end
      end
      ST_EXEC: begin
        case (cls_q)
          CLS_BEQ, CLS_BNE: begin
            retired = 1'b1;
            state_d = ST_FETCH;
            if ((cls_q == CLS_BEQ) == alu_zero) begin
              pc_wren = 1'b1;
              pc_src  = PC_SRC_BRANCH;
            end
          end
          CLS_LW, CLS_SW: state_d = ST_MEM;
          default:        state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_wren     = (cls_q == CLS_SW);
        if (mem_ready) begin
          if (cls_q == CLS_SW) begin
            retired = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (wait_q == WAIT_LAST) begin
          bus_err = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_WB: begin
        reg_file_wren = 1'b1;
        reg_wsel      = (cls_q == CLS_LW) ? WSEL_MEM : WSEL_ALU;
        retired       = 1'b1;
        state_d       = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: each step sets inputs after a rising
// edge, checks the full output vector at the falling edge.
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = 6'h00;
  logic [5:0] funct = 6'h00;
  logic       alu_zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       ir_wren, pc_wren, mem_req, mem_wren, mem_addr_sel;
  logic       reg_file_wren, retired, illegal, bus_err;
  logic [1:0] pc_src, reg_wsel;
  logic [2:0] state;

  int n_asserts = 0;
  int n_fail = 0;

  cpu_sequencer #(.MEM_TIMEOUT(15)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .op            (op),
    .funct         (funct),
    .alu_zero      (alu_zero),
    .mem_ready     (mem_ready),
    .ir_wren       (ir_wren),
    .pc_wren       (pc_wren),
    .pc_src        (pc_src),
    .mem_req       (mem_req),
    .mem_wren      (mem_wren),
    .mem_addr_sel  (mem_addr_sel),
    .reg_file_wren (reg_file_wren),
    .reg_wsel      (reg_wsel),
    .retired       (retired),
    .illegal       (illegal),
    .bus_err       (bus_err),
    .state         (state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  logic [15:0] obs;
  assign obs = {ir_wren, pc_wren, pc_src, mem_req, mem_wren, mem_addr_sel,
                reg_file_wren, reg_wsel, retired, illegal, bus_err, state};

  // Expected output vector, same field order as obs.
  function automatic logic [15:0] ev(input logic [2:0] st, input logic ir,
      input logic pcw, input logic [1:0] pcs, input logic mreq,
      input logic mw, input logic mas, input logic rfw,
      input logic [1:0] rws, input logic ret, input logic ill,
      input logic be);
    return {ir, pcw, pcs, mreq, mw, mas, rfw, rws, ret, ill, be, st};
  endfunction

  // Check outputs at the falling edge, then advance past the next rising edge.
  task automatic cyc(input string tag, input logic [15:0] exp_v);
    @(negedge clk);
    n_asserts++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
    @(posedge clk);
    #1;
  endtask

  logic [15:0] zero_idle, fetch_ok, fetch_wait, quiet_dec, quiet_exec;

  initial begin
    zero_idle  = ev(3'd0, 0,0,2'b00, 0,0,0, 0,2'b00, 0,0,0);
    fetch_ok   = ev(3'd1, 1,1,2'b00, 1,0,0, 0,2'b00, 0,0,0);
    fetch_wait = ev(3'd1, 0,0,2'b00, 1,0,0, 0,2'b00, 0,0,0);
    quiet_dec  = ev(3'd2, 0,0,2'b00, 0,0,0, 0,2'b00, 0,0,0);
    quiet_exec = ev(3'd3, 0,0,2'b00, 0,0,0, 0,2'b00, 0,0,0);

    // reset held
    cyc("reset0", zero_idle);
    cyc("reset1", zero_idle);
    rst_n = 1'b1;
    cyc("idle", zero_idle);

    // ADDU, zero wait states: 1,2,3,5
    mem_ready = 1'b1; op = 6'h00; funct = 6'h21;
    cyc("addu_fetch", fetch_ok);
    cyc("addu_dec", quiet_dec);
    cyc("addu_exec", quiet_exec);
    cyc("addu_wb", ev(3'd5, 0,0,2'b00, 0,0,0, 1,2'b00, 1,0,0));

    // LW with three wait states in MEM
    op = 6'h23;
    cyc("lw_fetch", fetch_ok);
    cyc("lw_dec", quiet_dec);
    cyc("lw_exec", quiet_exec);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      cyc("lw_mem_wait", ev(3'd4, 0,0,2'b00, 1,0,1, 0,2'b00, 0,0,0));
    mem_ready = 1'b1;
    cyc("lw_mem_done", ev(3'd4, 0,0,2'b00, 1,0,1, 0,2'b00, 0,0,0));
    cyc("lw_wb", ev(3'd5, 0,0,2'b00, 0,0,0, 1,2'b01, 1,0,0));

    // SW, zero wait states
    op = 6'h2B;
    cyc("sw_fetch", fetch_ok);
    cyc("sw_dec", quiet_dec);
    cyc("sw_exec", quiet_exec);
    cyc("sw_mem", ev(3'd4, 0,0,2'b00, 1,1,1, 0,2'b00, 1,0,0));

    // BEQ taken
    op = 6'h04; alu_zero = 1'b1;
    cyc("beq_fetch", fetch_ok);
    cyc("beq_dec", quiet_dec);
    cyc("beq_exec", ev(3'd3, 0,1,2'b01, 0,0,0, 0,2'b00, 1,0,0));

    // BNE not taken (alu_zero=1)
    op = 6'h05;
    cyc("bne_fetch", fetch_ok);
    cyc("bne_dec", quiet_dec);
    cyc("bne_exec", ev(3'd3, 0,0,2'b00, 0,0,0, 0,2'b00, 1,0,0));

    // BNE taken (alu_zero=0)
    alu_zero = 1'b0;
    cyc("bne_t_fetch", fetch_ok);
    cyc("bne_t_dec", quiet_dec);
    cyc("bne_t_exec", ev(3'd3, 0,1,2'b01, 0,0,0, 0,2'b00, 1,0,0));

    // JAL
    op = 6'h03;
    cyc("jal_fetch", fetch_ok);
    cyc("jal_dec", ev(3'd2, 0,1,2'b10, 0,0,0, 1,2'b10, 1,0,0));

    // JR
    op = 6'h00; funct = 6'h08;
    cyc("jr_fetch", fetch_ok);
    cyc("jr_dec", ev(3'd2, 0,1,2'b11, 0,0,0, 0,2'b00, 1,0,0));

    // JALR
    funct = 6'h09;
    cyc("jalr_fetch", fetch_ok);
    cyc("jalr_dec", ev(3'd2, 0,1,2'b11, 0,0,0, 1,2'b10, 1,0,0));

    // illegal opcode 3F
    op = 6'h3F;
    cyc("ill_op_fetch", fetch_ok);
    cyc("ill_op_dec", ev(3'd2, 0,0,2'b00, 0,0,0, 0,2'b00, 0,1,0));

    // illegal R-type funct 01
    op = 6'h00; funct = 6'h01;
    cyc("ill_fn_fetch", fetch_ok);
    cyc("ill_fn_dec", ev(3'd2, 0,0,2'b00, 0,0,0, 0,2'b00, 0,1,0));

    // FETCH timeout: bus_err on the 15th request cycle, then refetch (J)
    mem_ready = 1'b0; op = 6'h02;
    for (int i = 0; i < 14; i++) cyc("to_wait", fetch_wait);
    cyc("to_bus_err", ev(3'd1, 0,0,2'b00, 1,0,0, 0,2'b00, 0,0,1));
    cyc("to_refetch_wait", fetch_wait);
    mem_ready = 1'b1;
    cyc("to_refetch", fetch_ok);
    cyc("to_j_dec", ev(3'd2, 0,1,2'b10, 0,0,0, 0,2'b00, 1,0,0));

    // mem_ready on the 15th cycle wins over the timeout
    mem_ready = 1'b0;
    for (int i = 0; i < 14; i++) cyc("race_wait", fetch_wait);
    mem_ready = 1'b1;
    cyc("race_done", fetch_ok);
    cyc("race_j_dec", ev(3'd2, 0,1,2'b10, 0,0,0, 0,2'b00, 1,0,0));

    // reset pulsed mid-MEM of an LW
    op = 6'h23;
    cyc("rst_fetch", fetch_ok);
    cyc("rst_dec", quiet_dec);
    cyc("rst_exec", quiet_exec);
    mem_ready = 1'b0;
    cyc("rst_mem", ev(3'd4, 0,0,2'b00, 1,0,1, 0,2'b00, 0,0,0));
    #2 rst_n = 1'b0;
    cyc("rst_in_mem", zero_idle);
    cyc("rst_hold", zero_idle);
    rst_n = 1'b1;
    cyc("rst_idle", zero_idle);
    cyc("rst_fetch_req", fetch_wait);
    mem_ready = 1'b1; op = 6'h00; funct = 6'h21;
    cyc("rst_addu_fetch", fetch_ok);
    cyc("rst_addu_dec", quiet_dec);
    cyc("rst_addu_exec", quiet_exec);
    cyc("rst_addu_wb", ev(3'd5, 0,0,2'b00, 0,0,0, 1,2'b00, 1,0,0));

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have ports clk (input, 1, single clock, rising edge) and rst_n (input, 1, reset, asynchronous, active-low); there is one clock and no other reset.
REQ-002 SHALL have: op (input, 6, IR[31:26]); funct (input, 6, IR[5:0]); alu_zero (input, 1, ALU zero flag); mem_ready (input, 1, memory completes the access this cycle).
REQ-003 SHALL have: ir_wren (output, 1, load IR); pc_wren (output, 1, load PC); pc_src (output, 2: 00 PC+4, 01 branch target, 10 jump target, 11 register rs).
REQ-004 SHALL have: mem_req (output, 1); mem_wren (output, 1); mem_addr_sel (output, 1: 0 PC, 1 ALU result).
REQ-005 SHALL have: reg_file_wren (output, 1); reg_wsel (output, 2: 00 ALU, 01 memory data, 10 PC link); retired (output, 1, pulse); illegal (output, 1, pulse); bus_err (output, 1, pulse); state (output, 3, debug).
REQ-006 SHALL have parameter MEM_TIMEOUT, default 15, giving the maximum number of mem_req cycles without mem_ready.

Function
REQ-007 SHALL implement states IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5 and drive the current state on the state output.
REQ-008 IDLE: all outputs 0; next state FETCH unconditionally.
REQ-009 FETCH: mem_req=1, mem_addr_sel=0; on mem_ready, ir_wren=1, pc_wren=1 with pc_src=00 in the same cycle, then go to DECODE; otherwise stay in FETCH.
REQ-010 DECODE (1 cycle): SHALL latch the instruction class from op/funct into an internal register; later states use only the latched class.
REQ-011 DECODE, J(02)/JAL(03): pc_wren=1, pc_src=10; JAL also reg_file_wren=1, reg_wsel=10; retired=1; go to FETCH.
REQ-012 DECODE, JR(00/08)/JALR(00/09): pc_wren=1, pc_src=11; JALR also reg_file_wren=1, reg_wsel=10; retired=1; go to FETCH.
REQ-013 DECODE, illegal encoding: illegal=1, no writes, retired=0, go to FETCH. Legal R-type funct values are 00,02,03,08,09,20-27,2A. Legal op values are 00,02,03,04,05,08,09,0A,0C,0D,23,2B.
REQ-014 DECODE, all other legal instructions: go to EXEC.
REQ-015 EXEC, BEQ(04) with alu_zero=1 or BNE(05) with alu_zero=0: pc_wren=1, pc_src=01. Any branch: retired=1, go to FETCH.
REQ-016 EXEC, LW(23)/SW(2B): go to MEM. All other instructions: go to WB.
REQ-017 MEM: mem_req=1, mem_addr_sel=1, mem_wren=1 for SW only; on mem_ready, SW sets retired=1 and goes to FETCH, LW goes to WB; otherwise stay in MEM.
REQ-018 WB: reg_file_wren=1, reg_wsel=01 for LW and 00 otherwise; retired=1; go to FETCH.
REQ-019 A 4-bit wait counter SHALL clear on entry to FETCH/MEM and increment each cycle mem_req=1 without mem_ready. When it reaches MEM_TIMEOUT: bus_err=1 for one cycle, no ir_wren/pc_wren/retire, go to FETCH; the same PC is refetched.
REQ-020 If mem_ready and timeout coincide, mem_ready SHALL win with a normal completion and no bus_err.
REQ-021 All outputs other than state SHALL be decoded combinationally from state, latched class, alu_zero and mem_ready; no output SHALL be asserted outside its listed state.
REQ-022 The following SHALL be single-cycle pulses: retired, illegal, bus_err. At most one of retired/illegal/bus_err SHALL be asserted per cycle.
REQ-023 Latency SHALL be: J/JR 2 cycles; branch 3; ALU 4; SW 4; LW 5, each with zero memory wait states.

Reset
REQ-024 rst_n low SHALL asynchronously force state=IDLE, wait counter=0 and class=0; all outputs SHALL read 0 during reset.
REQ-025 rst_n asserted mid-access SHALL abandon the instruction with no write; after release the sequence is IDLE, then FETCH with mem_req=1 in the second cycle.

Structure
REQ-026 A shared cpu_defs package/header SHALL hold the state encodings, opcode/funct constants, and the pc_src and reg_wsel encodings; the decoder uses the same header.
REQ-027 One combinational sub-module, instr_classifier (op, funct -> class, legal), SHALL be instantiated; everything else lives in cpu_sequencer.

Verification
REQ-028 ADDU with mem_ready always 1: states 1,2,3,5,1; reg_file_wren=1 with reg_wsel=00 in WB; retired once; 4 cycles.
REQ-029 LW with mem_ready delayed 3 cycles in MEM: mem_addr_sel=1 and mem_wren=0 for 4 cycles; WB reg_wsel=01; total 8 cycles.
REQ-030 BEQ alu_zero=1 -> pc_wren with pc_src=01 in EXEC; BNE alu_zero=1 -> no pc_wren; both retire.
REQ-031 JAL -> DECODE: pc_wren=1, pc_src=10, reg_file_wren=1, reg_wsel=10; op=3F -> illegal pulse, no writes, back to FETCH.
REQ-032 mem_ready held 0 in FETCH -> bus_err on the 15th mem_req cycle, no ir_wren, FETCH re-entered; rst_n pulsed in MEM -> IDLE, all outputs 0, no write.
